// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding,
// the A/B grant encoding and the round-robin pick helper.
package fifo_wr_arb_pkg;

    // Arbiter states. IDLE is the only state in which a requester can be accepted.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_A    = 2'd1,
        WR_B_LO = 2'd2,
        WR_B_HI = 2'd3
    } state_e;

    // Which requester won the most recent grant.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // Number of FIFO bytes carried by one requester B word.
    localparam int B_BYTES = 2;

    // Round-robin choice for a tie: the winner is whoever did not win last.
    // With only one requester valid, that requester wins outright.
    function automatic grant_e pickGrant(input logic aValid,
                                         input logic bValid,
                                         input grant_e last);
        grant_e winner;
        winner = GRANT_A;
        if (aValid && bValid) begin
            winner = (last == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (bValid) begin
            winner = GRANT_B;
        end
        return winner;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle between the two requesters, the arbiter and the FIFO
// write port. The slave modport is the arbiter's view; the master modport is
// the view of whatever drives the requesters and the FULL flag.
interface fifo_wr_arb_if #(
    parameter int DATA_WIDTH = 8
);

    logic                      a_valid;
    logic [DATA_WIDTH-1:0]     a_data;
    logic                      a_ready;
    logic                      b_valid;
    logic [2*DATA_WIDTH-1:0]   b_data;
    logic                      b_ready;
    logic                      full;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      w_inc;
    logic                      busy;

    modport slave (
        input  a_valid,
        input  a_data,
        output a_ready,
        input  b_valid,
        input  b_data,
        output b_ready,
        input  full,
        output wr_data,
        output w_inc,
        output busy
    );

    modport master (
        output a_valid,
        output a_data,
        input  a_ready,
        output b_valid,
        output b_data,
        input  b_ready,
        output full,
        input  wr_data,
        input  w_inc,
        input  busy
    );

endinterface

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter in front of an asynchronous FIFO's write port.
// Requester A supplies single bytes, requester B supplies two-byte words that
// are written low byte first and never split by an A byte. Acceptance only
// happens in IDLE, so every transaction is followed by one IDLE cycle.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fifo_wr_arb_if.slave   bus
);

    state_e                 r_state;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic [DATA_WIDTH-1:0]  r_holdHi;
    grant_e                 r_last;

    logic                   w_idle;
    logic                   w_active;
    grant_e                 w_winner;
    logic                   w_grantA;
    logic                   w_grantB;

    // Accept decisions and write strobe are combinational; everything is
    // forced quiet while reset is held so nothing leaks out mid-reset.
    always_comb begin
        w_idle   = (r_state == IDLE) && !i_rst;
        w_active = (r_state != IDLE) && !i_rst;
        w_winner = pickGrant(bus.a_valid, bus.b_valid, r_last);
        w_grantA = w_idle && bus.a_valid && (w_winner == GRANT_A);
        w_grantB = w_idle && bus.b_valid && (w_winner == GRANT_B);
    end

    assign bus.a_ready = w_grantA;
    assign bus.b_ready = w_grantB;
    assign bus.w_inc   = w_active && !bus.full;
    assign bus.busy    = w_active;
    assign bus.wr_data = i_rst ? '0 : r_hold;

    // Arbiter FSM: capture the winner into the holding registers in IDLE, then
    // step through the write states only on cycles where the FIFO takes a byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_holdHi <= '0;
            r_last   <= GRANT_B;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantA) begin
                        r_hold  <= bus.a_data;
                        r_last  <= GRANT_A;
                        r_state <= WR_A;
                    end else if (w_grantB) begin
                        r_hold   <= bus.b_data[DATA_WIDTH-1:0];
                        r_holdHi <= bus.b_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_last   <= GRANT_B;
                        r_state  <= WR_B_LO;
                    end
                end
                WR_A: begin
                    if (!bus.full) begin
                        r_state <= IDLE;
                    end
                end
                WR_B_LO: begin
                    if (!bus.full) begin
                        r_hold  <= r_holdHi;
                        r_state <= WR_B_HI;
                    end
                end
                WR_B_HI: begin
                    if (!bus.full) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Safety properties: never two accepts at once and never a write into a full FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(bus.a_ready && bus.b_ready));
            assert (!(bus.w_inc && bus.full));
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of the bytes the FIFO must receive.
module tb_fifo_wr_arb;

    logic clk;
    logic rst;

    fifo_wr_arb_if #(.DATA_WIDTH(8)) bus ();

    fifo_wr_arb #(.DATA_WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int nVectors;
    int nMiscompares;

    logic [7:0] mQ[$];
    logic [7:0] mHold;
    logic       mLastB;
    logic       mAccA;
    logic       mAccB;
    logic [7:0] wrLog[$];

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [7:0] ad,
                                 input logic bv, input logic [15:0] bd,
                                 input logic fl, input logic rs);
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.full    = fl;
        rst         = rs;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
        #1;
    endtask

    // Reference model: pending FIFO bytes live in a queue; the arbiter is idle
    // exactly when the queue is empty. Checks and then advances once per cycle.
    always @(negedge clk) begin : modelBlk
        logic [7:0] eData;
        logic       eInc;
        logic       eBusy;
        logic       eAR;
        logic       eBR;
        eAR = 1'b0;
        eBR = 1'b0;
        if (rst) begin
            eData = 8'h00;
            eInc  = 1'b0;
            eBusy = 1'b0;
        end else if (mQ.size() == 0) begin
            eData = mHold;
            eInc  = 1'b0;
            eBusy = 1'b0;
            eAR   = bus.a_valid && (!bus.b_valid || mLastB);
            eBR   = bus.b_valid && (!bus.a_valid || !mLastB);
        end else begin
            eData = mQ[0];
            eInc  = !bus.full;
            eBusy = 1'b1;
        end
        checkOutput("model_a_ready", {15'd0, bus.a_ready}, {15'd0, eAR});
        checkOutput("model_b_ready", {15'd0, bus.b_ready}, {15'd0, eBR});
        checkOutput("model_w_inc",   {15'd0, bus.w_inc},   {15'd0, eInc});
        checkOutput("model_busy",    {15'd0, bus.busy},    {15'd0, eBusy});
        checkOutput("model_wr_data", {8'd0, bus.wr_data},  {8'd0, eData});
        if (bus.w_inc) begin
            wrLog.push_back(bus.wr_data);
        end
        mAccA = eAR;
        mAccB = eBR;
        if (rst) begin
            mQ.delete();
            mHold  = 8'h00;
            mLastB = 1'b1;
        end else if (mQ.size() == 0) begin
            if (eAR) begin
                mQ.push_back(bus.a_data);
                mHold  = bus.a_data;
                mLastB = 1'b0;
            end else if (eBR) begin
                mQ.push_back(bus.b_data[7:0]);
                mQ.push_back(bus.b_data[15:8]);
                mHold  = bus.b_data[7:0];
                mLastB = 1'b1;
            end
        end else if (!bus.full) begin
            void'(mQ.pop_front());
            if (mQ.size() != 0) begin
                mHold = mQ[0];
            end
        end
    end

    // Directed scenarios first, then randomized traffic with occasional resets.
    initial begin
        logic [7:0] tieExp[6];
        logic       aPend;
        logic       bPend;
        logic [7:0] aDat;
        logic [15:0] bDat;
        nVectors     = 0;
        nMiscompares = 0;
        mHold  = 8'h00;
        mLastB = 1'b1;
        mAccA  = 1'b0;
        mAccB  = 1'b0;
        tieExp = '{8'h11, 8'h33, 8'h22, 8'h11, 8'h33, 8'h22};

        applyStimulus(1'b1, 8'h77, 1'b1, 16'h1234, 1'b0, 1'b1);
        atNeg();
        checkOutput("rst_a_ready", {15'd0, bus.a_ready}, 16'd0);
        checkOutput("rst_b_ready", {15'd0, bus.b_ready}, 16'd0);
        checkOutput("rst_w_inc",   {15'd0, bus.w_inc},   16'd0);
        checkOutput("rst_busy",    {15'd0, bus.busy},    16'd0);
        checkOutput("rst_wr_data", {8'd0, bus.wr_data},  16'd0);
        nextCycle();
        nextCycle();

        applyStimulus(1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0, 1'b0);
        atNeg();
        checkOutput("loneA_ready", {15'd0, bus.a_ready}, 16'd1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        atNeg();
        checkOutput("loneA_w_inc", {15'd0, bus.w_inc}, 16'd1);
        checkOutput("loneA_data",  {8'd0, bus.wr_data}, 16'h005A);
        nextCycle();
        atNeg();
        checkOutput("loneA_busy_low", {15'd0, bus.busy}, 16'd0);
        nextCycle();

        applyStimulus(1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        atNeg();
        checkOutput("loneB_ready", {15'd0, bus.b_ready}, 16'd1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        atNeg();
        checkOutput("loneB_ready_pulse", {15'd0, bus.b_ready}, 16'd0);
        checkOutput("loneB_lo_inc",  {15'd0, bus.w_inc}, 16'd1);
        checkOutput("loneB_lo_data", {8'd0, bus.wr_data}, 16'h00EF);
        nextCycle();
        atNeg();
        checkOutput("loneB_hi_inc",  {15'd0, bus.w_inc}, 16'd1);
        checkOutput("loneB_hi_data", {8'd0, bus.wr_data}, 16'h00BE);
        nextCycle();

        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        nextCycle();
        wrLog.delete();
        applyStimulus(1'b1, 8'h11, 1'b1, 16'h2233, 1'b0, 1'b0);
        repeat (10) nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (2) nextCycle();
        checkOutput("tie_count", 16'(wrLog.size()), 16'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("tie_byte%0d", i),
                        (i < wrLog.size()) ? {8'd0, wrLog[i]} : 16'hFFFF,
                        {8'd0, tieExp[i]});
        end

        wrLog.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hA1B2, 1'b0, 1'b0);
        atNeg();
        checkOutput("bp_b_ready", {15'd0, bus.b_ready}, 16'd1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            atNeg();
            checkOutput($sformatf("bp_stall_inc%0d", i), {15'd0, bus.w_inc}, 16'd0);
            checkOutput($sformatf("bp_stall_busy%0d", i), {15'd0, bus.busy}, 16'd1);
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) nextCycle();
        checkOutput("bp_count", 16'(wrLog.size()), 16'd2);
        checkOutput("bp_lo", (wrLog.size() > 0) ? {8'd0, wrLog[0]} : 16'hFFFF, 16'h00B2);
        checkOutput("bp_hi", (wrLog.size() > 1) ? {8'd0, wrLog[1]} : 16'hFFFF, 16'h00A1);

        wrLog.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hA1B2, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        atNeg();
        checkOutput("rstHi_w_inc", {15'd0, bus.w_inc}, 16'd0);
        checkOutput("rstHi_busy",  {15'd0, bus.busy},  16'd0);
        nextCycle();
        applyStimulus(1'b1, 8'h11, 1'b1, 16'h2233, 1'b0, 1'b0);
        atNeg();
        checkOutput("rstHi_tie_a", {15'd0, bus.a_ready}, 16'd1);
        checkOutput("rstHi_tie_b", {15'd0, bus.b_ready}, 16'd0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (4) nextCycle();
        checkOutput("rstHi_count", 16'(wrLog.size()), 16'd2);
        checkOutput("rstHi_lo",  (wrLog.size() > 0) ? {8'd0, wrLog[0]} : 16'hFFFF, 16'h00B2);
        checkOutput("rstHi_next", (wrLog.size() > 1) ? {8'd0, wrLog[1]} : 16'hFFFF, 16'h0011);

        aPend = 1'b0;
        bPend = 1'b0;
        aDat  = 8'h00;
        bDat  = 16'h0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (aPend && mAccA) aPend = 1'b0;
            if (bPend && mAccB) bPend = 1'b0;
            if (!aPend && ($urandom_range(0, 2) == 0)) begin
                aPend = 1'b1;
                aDat  = 8'($urandom);
            end
            if (!bPend && ($urandom_range(0, 2) == 0)) begin
                bPend = 1'b1;
                bDat  = 16'($urandom);
            end
            applyStimulus(aPend, aDat, bPend, bDat,
                          ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 199) == 0));
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (5) nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, 8: FIFO write-port byte width; requester B word is 2*DATA_WIDTH.
REQ-002 CLK  in  1  single clock, the FIFO write-domain clock.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 A_VALID  in  1  requester A (register file) has one byte pending.
REQ-005 A_DATA  in  DATA_WIDTH  requester A byte.
REQ-006 A_READY  out  1  requester A byte accepted this cycle.
REQ-007 B_VALID  in  1  requester B (ALU) has one word pending.
REQ-008 B_DATA  in  2*DATA_WIDTH  requester B word.
REQ-009 B_READY  out  1  requester B word accepted this cycle.
REQ-010 FULL  in  1  FIFO full flag, write domain.
REQ-011 WR_DATA  out  DATA_WIDTH  byte to FIFO write data.
REQ-012 W_INC  out  1  FIFO write strobe; one byte per high cycle.
REQ-013 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, WR_A, WR_B_LO, WR_B_HI; one state register, one DATA_WIDTH holding register HOLD, one B high-byte register HOLD_HI, one LAST grant flag.
REQ-015 IDLE, only A_VALID: A_READY=1 combinationally; HOLD<=A_DATA; LAST<=A; next WR_A.
REQ-016 IDLE, only B_VALID: B_READY=1 combinationally; HOLD<=B_DATA[DATA_WIDTH-1:0]; HOLD_HI<=B_DATA[2*DATA_WIDTH-1:DATA_WIDTH]; LAST<=B; next WR_B_LO.
REQ-017 IDLE, both valid: grant goes to the requester not equal to LAST (round-robin); the loser sees READY=0 and keeps VALID/data stable.
REQ-018 IDLE, neither valid: stay IDLE; A_READY=B_READY=W_INC=0.
REQ-019 READY is asserted only in IDLE and at most one READY per cycle.
REQ-020 WR_DATA=HOLD in every state; W_INC = (state in WR_A/WR_B_LO/WR_B_HI) AND NOT FULL, combinational.
REQ-021 WR_A: on W_INC next IDLE; while FULL=1 hold state and HOLD.
REQ-022 WR_B_LO: on W_INC HOLD<=HOLD_HI, next WR_B_HI; while FULL=1 hold.
REQ-023 WR_B_HI: on W_INC next IDLE; while FULL=1 hold.
REQ-024 B word is atomic: low byte then high byte, never interleaved with an A byte.
REQ-025 Latency: accept in cycle N, first W_INC earliest cycle N+1; one IDLE cycle separates consecutive transactions; peak throughput A = 1 byte/2 cycles, B = 2 bytes/3 cycles.
REQ-026 No byte is written while FULL=1, none is dropped or duplicated; FULL may toggle any cycle.

Reset
REQ-027 RST=1 at a CLK edge: state<=IDLE, HOLD<=0, HOLD_HI<=0, LAST<=B (A wins first tie).
REQ-028 During and after reset: W_INC=0, A_READY=0 while RST=1, B_READY=0 while RST=1, BUSY=0, WR_DATA=0.
REQ-029 Reset mid-transaction discards the held byte/word; no partial B completion after reset.

Structure
REQ-030 Shared package fifo_wr_arb_pkg holds state encoding constants and the A/B grant encoding; DATA_WIDTH stays a module parameter.
REQ-031 Single module, no sub-module; instantiated in the write clock domain beside the FIFO top, driving its W_INC/WR_DATA and consuming its FULL.

Verification
REQ-032 Lone A: A_VALID=1, A_DATA=0x5A, FULL=0 -> A_READY cycle N, W_INC=1 with WR_DATA=0x5A cycle N+1, BUSY low cycle N+2.
REQ-033 Lone B: B_DATA=0xBEEF, FULL=0 -> W_INC with 0xEF then 0xBE on consecutive cycles, B_READY single pulse.
REQ-034 Tie after reset: A=0x11, B=0x2233 both valid continuously -> writes 0x11, 0x33, 0x22, 0x11, 0x33, 0x22 (strict alternation).
REQ-035 Backpressure: B=0xA1B2 accepted, FULL=1 for 4 cycles after low-byte state entry -> W_INC=0 for 4 cycles, then 0xB2, 0xA1, no loss or duplicate.
REQ-036 Reset in WR_B_HI: RST=1 one cycle -> W_INC=0, state IDLE, 0xA1-style high byte never written; next tie grants A.
